pw_pattern_match: RTL and testbench

- Byte-stream pattern matcher that produces the `I_match` input of the trigger counter stage directly downstream.
- Shifts captured USB bytes into a history window and compares the most recent N bytes against a masked pattern from the register block.
- Emits a one-cycle match pulse.
- Arm/disarm control sequences it through a small state machine.

---
 rtl/pw_pattern_match_if.sv | 33 +++
 rtl/pw_pattern_match.sv | 127 ++++++++++++
 tb/tb_pw_pattern_match.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pw_pattern_match_if.sv
// ============================================================================
// Module   : pw_pattern_match_if
// Purpose  : Byte-stream, pattern-config and status bundle for pw_pattern_match.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pw_pattern_match_if #(
  parameter int pBYTES = 8
);
  logic [7:0]          I_data;
  logic                I_data_valid;
  logic                I_arm;
  logic                I_disarm;
  logic [pBYTES*8-1:0] I_pattern;
  logic [pBYTES*8-1:0] I_mask;
  logic [3:0]          I_bytes;
  logic                O_match;
  logic                O_armed;
  logic [1:0]          O_state;

  modport master (
    output I_data, I_data_valid, I_arm, I_disarm, I_pattern, I_mask, I_bytes,
    input  O_match, O_armed, O_state
  );

  modport slave (
    input  I_data, I_data_valid, I_arm, I_disarm, I_pattern, I_mask, I_bytes,
    output O_match, O_armed, O_state
  );
endinterface

`default_nettype wire

// File: rtl/pw_pattern_match.sv
// ============================================================================
// Module   : pw_pattern_match
// Purpose  : Masked byte-pattern matcher with arm/disarm FSM; optional
//            auto-rearm after each match under PW_PATTERN_REARM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pw_pattern_match #(
  parameter int pBYTES = 8
) (
  input  wire logic            trigger_clk,
  input  wire logic            reset_i,
  pw_pattern_match_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_FIRED = 2'b10
  } state_t;

  localparam logic [3:0] FILL_MAX = 4'(pBYTES);

  state_t              state_q, state_d;
  logic [pBYTES*8-1:0] history_q, history_d;
  logic [3:0]          fill_q, fill_d;
  logic                match_q, match_d;

  logic [3:0]          eff_len;
  logic                mismatch;
  logic                hit;

  always_comb begin
    if (bus.I_bytes == 4'd0) begin
      eff_len = 4'd1;
    end else if (bus.I_bytes > FILL_MAX) begin
      eff_len = FILL_MAX;
    end else begin
      eff_len = bus.I_bytes;
    end
  end

  // Only the L most recent bytes take part; older bytes are ignored even if masked.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < pBYTES; i++) begin
      if ((4'(i) < eff_len) &&
          (|((history_q[i*8 +: 8] ^ bus.I_pattern[i*8 +: 8]) & bus.I_mask[i*8 +: 8]))) begin
        mismatch = 1'b1;
      end
    end
  end

  assign hit = (fill_q >= eff_len) && !mismatch;

  always_comb begin
    history_d = history_q;
    if (bus.I_data_valid) begin
      for (int k = pBYTES - 1; k > 0; k--) begin
        history_d[k*8 +: 8] = history_q[(k-1)*8 +: 8];
      end
      history_d[7:0] = bus.I_data;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    fill_d  = fill_q;
    if (bus.I_data_valid && (fill_q < FILL_MAX)) begin
      fill_d = fill_q + 4'd1;
    end

    if (bus.I_disarm) begin
      state_d = S_IDLE;
    end else if (bus.I_arm) begin
      // Arming restarts the window so stale pre-arm history cannot match.
      state_d = S_ARMED;
      fill_d  = bus.I_data_valid ? 4'd1 : 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ARMED: begin
          if (hit) begin
            match_d = 1'b1;
`ifdef PW_PATTERN_REARM_EN
            state_d = S_ARMED;
            fill_d  = bus.I_data_valid ? 4'd1 : 4'd0;
`else
            state_d = S_FIRED;
`endif
          end
        end
        S_FIRED: begin
          state_d = S_FIRED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      history_q <= '0;
      fill_q    <= 4'd0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
    end
  end

  assign bus.O_match = match_q;
  assign bus.O_armed = (state_q == S_ARMED);
  assign bus.O_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pw_pattern_match.sv
// ============================================================================
// Module   : tb_pw_pattern_match
// Purpose  : Directed vector bench for pw_pattern_match (pBYTES = 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pw_pattern_match;

  localparam int PB = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRED = 2'd2;
`ifdef PW_PATTERN_REARM_EN
  localparam logic [1:0] ST_AFTER = ST_ARMED;
  localparam logic       REARM    = 1'b1;
`else
  localparam logic [1:0] ST_AFTER = ST_FIRED;
  localparam logic       REARM    = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        arm;
    logic        disarm;
    logic [3:0]  nbytes;
    logic [63:0] pat;
    logic [63:0] mask;
    logic        exp_match;
    logic [1:0]  exp_state;
  } vec_t;

  logic trigger_clk;
  logic reset_i;
  int   checks;
  int   errors;

  vec_t        vecs[$];
  logic [3:0]  cur_b;
  logic [63:0] cur_p;
  logic [63:0] cur_m;

  pw_pattern_match_if #(.pBYTES(PB)) bus_if ();

  pw_pattern_match #(.pBYTES(PB)) dut (
    .trigger_clk (trigger_clk),
    .reset_i     (reset_i),
    .bus         (bus_if)
  );

  initial trigger_clk = 1'b0;
  always #5 trigger_clk = ~trigger_clk;

  function automatic void cfg(input logic [3:0] b, input logic [63:0] p, input logic [63:0] m);
    cur_b = b;
    cur_p = p;
    cur_m = m;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic a,
                              input logic da, input logic em, input logic [1:0] es);
    vec_t r;
    r.data = d; r.valid = v; r.arm = a; r.disarm = da;
    r.nbytes = cur_b; r.pat = cur_p; r.mask = cur_m;
    r.exp_match = em; r.exp_state = es;
    return r;
  endfunction

  function automatic void add(input logic [7:0] d, input logic v, input logic a,
                              input logic da, input logic em, input logic [1:0] es);
    vecs.push_back(mk(d, v, a, da, em, es));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic rst, input string tag);
    @(negedge trigger_clk);
    reset_i             = rst;
    bus_if.I_data       = v.data;
    bus_if.I_data_valid = v.valid;
    bus_if.I_arm        = v.arm;
    bus_if.I_disarm     = v.disarm;
    bus_if.I_bytes      = v.nbytes;
    bus_if.I_pattern    = v.pat;
    bus_if.I_mask       = v.mask;
    @(posedge trigger_clk);
    #1;
    check({tag, " match"}, {7'd0, bus_if.O_match}, {7'd0, v.exp_match});
    check({tag, " state"}, {6'd0, bus_if.O_state}, {6'd0, v.exp_state});
    check({tag, " armed"}, {7'd0, bus_if.O_armed}, {7'd0, (v.exp_state == ST_ARMED)});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_i = 1'b1;
    bus_if.I_data = 8'h00; bus_if.I_data_valid = 1'b0;
    bus_if.I_arm = 1'b0;   bus_if.I_disarm = 1'b0;
    bus_if.I_bytes = 4'd0; bus_if.I_pattern = '0; bus_if.I_mask = '0;

    // Basic 3-byte match, pulse 2 edges after the completing byte
    cfg(4'd3, 64'h0000_0000_0001_0203, ONES);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h01, 1, 0, 0, 0, ST_ARMED);
    add(8'h02, 1, 0, 0, 0, ST_ARMED);
    add(8'h03, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);
    add(8'h00, 0, 0, 0, 0, ST_FIRED);
    // Don't-care low nibble
    cfg(4'd1, 64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00F0);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'hA7, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);
    add(8'h00, 0, 0, 0, 0, ST_FIRED);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'hB7, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    // Stale history must not match after arm
    cfg(4'd2, 64'h0000_0000_0000_5566, ONES);
    add(8'h00, 0, 0, 1, 0, ST_IDLE);
    add(8'h55, 1, 0, 0, 0, ST_IDLE);
    add(8'h66, 1, 0, 0, 0, ST_IDLE);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    add(8'h55, 1, 0, 0, 0, ST_ARMED);
    add(8'h66, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);
    add(8'h00, 0, 0, 0, 0, ST_FIRED);
    // Disarm beats a pending hit; arm+disarm goes idle; arm beats hit
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h55, 1, 0, 0, 0, ST_ARMED);
    add(8'h66, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 1, 0, ST_IDLE);
    add(8'h00, 0, 0, 0, 0, ST_IDLE);
    add(8'h00, 0, 1, 1, 0, ST_IDLE);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    // I_bytes=12 clamps to 8; gapped valid
    cfg(4'd12, 64'h1122_3344_5566_7788, ONES);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    for (int i = 0; i < 7; i++) begin
      add(8'((i + 1) * 8'h11), 1, 0, 0, 0, ST_ARMED);
      add(8'h00, 0, 0, 0, 0, ST_ARMED);
    end
    add(8'h88, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);
    add(8'h00, 0, 0, 0, 0, ST_FIRED);
    // I_bytes=0 acts as L=1; higher bytes ignored despite full mask
    cfg(4'd0, 64'hDEAD_BEEF_0000_005A, ONES);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h5A, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);
    // All-zero mask fires on the L-th byte after arm
    cfg(4'd3, 64'h0000_0000_00AB_CDEF, 64'h0);
    add(8'h00, 0, 1, 0, 0, ST_ARMED);
    add(8'h01, 1, 0, 0, 0, ST_ARMED);
    add(8'h02, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 0, ST_ARMED);
    add(8'h03, 1, 0, 0, 0, ST_ARMED);
    add(8'h00, 0, 0, 0, 1, ST_FIRED);

    cfg(4'd0, 64'h0, 64'h0);
    apply(mk(8'h00, 0, 0, 0, 0, ST_IDLE), 1'b1, "reset0");
    apply(mk(8'h00, 0, 0, 0, 0, ST_IDLE), 1'b1, "reset1");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Reset mid-operation drops the pending match
    cfg(4'd1, 64'h0000_0000_0000_0042, ONES);
    apply(mk(8'h00, 0, 1, 0, 0, ST_ARMED), 1'b0, "midrst arm");
    apply(mk(8'h42, 1, 0, 0, 0, ST_ARMED), 1'b0, "midrst data");
    apply(mk(8'h00, 0, 0, 0, 0, ST_IDLE),  1'b1, "midrst rst");
    apply(mk(8'h00, 0, 0, 0, 0, ST_IDLE),  1'b0, "midrst post");
    apply(mk(8'h00, 0, 1, 0, 0, ST_ARMED), 1'b0, "midrst rearm");
    apply(mk(8'h00, 0, 0, 0, 0, ST_ARMED), 1'b0, "midrst nohist");

    // Back-to-back non-overlapping occurrences
    cfg(4'd2, 64'h0000_0000_0000_1122, ONES);
    apply(mk(8'h00, 0, 1, 0, 0, ST_ARMED), 1'b0, "b2b arm");
    apply(mk(8'h11, 1, 0, 0, 0, ST_ARMED), 1'b0, "b2b d0");
    apply(mk(8'h22, 1, 0, 0, 0, ST_ARMED), 1'b0, "b2b d1");
    apply(mk(8'h11, 1, 0, 0, 1, ST_AFTER), 1'b0, "b2b d2");
    apply(mk(8'h22, 1, 0, 0, 0, ST_AFTER), 1'b0, "b2b d3");
    apply(mk(8'h00, 0, 0, 0, REARM, ST_AFTER), 1'b0, "b2b p2");
    apply(mk(8'h00, 0, 0, 0, 0, ST_AFTER), 1'b0, "b2b end");

    // Overlapping occurrences produce only one pulse
    cfg(4'd2, 64'h0000_0000_0000_1111, ONES);
    apply(mk(8'h00, 0, 1, 0, 0, ST_ARMED), 1'b0, "ovl arm");
    apply(mk(8'h11, 1, 0, 0, 0, ST_ARMED), 1'b0, "ovl d0");
    apply(mk(8'h11, 1, 0, 0, 0, ST_ARMED), 1'b0, "ovl d1");
    apply(mk(8'h11, 1, 0, 0, 1, ST_AFTER), 1'b0, "ovl d2");
    apply(mk(8'h00, 0, 0, 0, 0, ST_AFTER), 1'b0, "ovl i0");
    apply(mk(8'h00, 0, 0, 0, 0, ST_AFTER), 1'b0, "ovl i1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
